// File: rtl/stream_arbiter_pkg.sv
// Shared types for the packet-level stream arbiter multiplexer.
package stream_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/stream_register_slice.sv
// Single-entry valid/ready register stage. It can accept a new beat whenever it is
// empty or its current beat is being taken in the same cycle.
module stream_register_slice #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_payload,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_payload
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] payload_q, payload_d;

    assign o_ready   = !valid_q || i_ready;
    assign o_valid   = valid_q;
    assign o_payload = payload_q;

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (i_valid && o_ready) begin
            valid_d   = 1'b1;
            payload_d = i_payload;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

endmodule

// File: rtl/stream_arbiter_mux.sv
// N:1 packet multiplexer: accepts a grant from an external round-robin arbiter,
// locks the granted channel until its last beat, and forwards beats through a register.
//
//   state | meaning
//   IDLE  | requests exposed to the arbiter; waiting for a grant on a valid channel
//   BUSY  | locked to sel; requests held low; beats flow from sel into the output register
module stream_arbiter_mux
    import stream_arbiter_pkg::*;
#(
    parameter int N           = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = (N == 1) ? 1 : $clog2(N)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [N-1:0]                   i_valid,
    output logic [N-1:0]                   o_ready,
    input  logic [N-1:0][DATA_WIDTH-1:0]   i_data,
    input  logic [N-1:0]                   i_last,
    output logic [N-1:0]                   o_request,
    input  logic [INDEX_WIDTH-1:0]         i_grant,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic                           o_last,
    output logic [INDEX_WIDTH-1:0]         o_index
);

    localparam int PAYLOAD_WIDTH = 1 + INDEX_WIDTH + DATA_WIDTH;

    state_e                   state_q, state_d;
    logic [INDEX_WIDTH-1:0]   sel_q, sel_d;
    logic [INDEX_WIDTH-1:0]   grant_idx;
    logic                     grant_valid;
    logic                     sel_valid;
    logic                     sel_last;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic                     slice_valid;
    logic                     slice_ready;
    logic [PAYLOAD_WIDTH-1:0] slice_out;

    // With a single channel the grant carries no information.
    assign grant_idx = (N == 1) ? '0 : i_grant;

    // Compare-based selection keeps out-of-range grant codes harmless when N is not a power of two.
    always_comb begin
        grant_valid = 1'b0;
        sel_valid   = 1'b0;
        sel_last    = 1'b0;
        sel_data    = '0;
        for (int c = 0; c < N; c++) begin
            if (grant_idx == INDEX_WIDTH'(c)) begin
                grant_valid = i_valid[c];
            end
            if (sel_q == INDEX_WIDTH'(c)) begin
                sel_valid = i_valid[c];
                sel_last  = i_last[c];
                sel_data  = i_data[c];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        o_request   = '0;
        o_ready     = '0;
        slice_valid = 1'b0;
        case (state_q)
            IDLE: begin
                o_request = i_valid;
                if (grant_valid) begin
                    sel_d   = grant_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int c = 0; c < N; c++) begin
                    o_ready[c] = (sel_q == INDEX_WIDTH'(c)) && slice_ready;
                end
                slice_valid = sel_valid;
                if (sel_valid && slice_ready && sel_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    stream_register_slice #(
        .WIDTH(PAYLOAD_WIDTH)
    ) u_out_slice (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (slice_valid),
        .o_ready  (slice_ready),
        .i_payload({sel_last, sel_q, sel_data}),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_payload(slice_out)
    );

    assign {o_last, o_index, o_data} = slice_out;

endmodule
